// File: rtl/diferential_cfg_loader.sv
// Shadow-loads CELLS configuration nibbles and commits them to the fabric in one cycle with a fab_rst pulse.
// Define DIFERENTIAL_CFG_CHECKSUM_EN to build the trailing XOR-checksum stage (CHECK state, err flag).
module diferential_cfg_loader #(
    parameter int CELLS = 9,
    parameter int CW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  din_valid,
    input  logic [CW-1:0]         din,
    output logic [CELLS*CW-1:0]   cell_cfg,
    output logic                  fab_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
    localparam logic [1:0] S_CHECK  = 2'd2;
`endif
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]          state;
    logic [IW-1:0]       idx;
    logic [CELLS*CW-1:0] shadow;
    logic                nib_vld;
    logic [CW-1:0]       nib_dat;
    logic                accepting;

`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
    logic [CW-1:0]       cks;
    assign accepting = (state == S_LOAD) || (state == S_CHECK);
`else
    assign accepting = (state == S_LOAD);
    assign err       = 1'b0;
`endif

    assign fab_rst = (state == S_COMMIT);
    assign busy    = (state != S_IDLE);

    // Nibbles are registered on acceptance; a nibble arriving with start belongs to no sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            nib_vld <= 1'b0;
            nib_dat <= '0;
        end else begin
            nib_vld <= din_valid && !start && accepting;
            nib_dat <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            shadow   <= '0;
            cell_cfg <= '0;
            done     <= 1'b0;
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
            err      <= 1'b0;
            cks      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        idx   <= '0;
                        done  <= 1'b0;
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
                        err   <= 1'b0;
                        cks   <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (start) begin
                        idx <= '0;
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
                        cks <= '0;
`endif
                    end else if (nib_vld) begin
                        shadow[int'(idx)*CW +: CW] <= nib_dat;
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
                        cks <= cks ^ nib_dat;
`endif
                        if (idx == LAST_IDX) begin
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
                            state <= S_CHECK;
`else
                            state <= S_COMMIT;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
                S_CHECK: begin
                    if (start) begin
                        state <= S_LOAD;
                        idx   <= '0;
                        cks   <= '0;
                    end else if (nib_vld) begin
                        if (nib_dat == cks) begin
                            state <= S_COMMIT;
                        end else begin
                            state <= S_IDLE;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                S_COMMIT: begin
                    cell_cfg <= shadow;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_diferential_cfg_loader.sv
// Scoreboarded bench for diferential_cfg_loader; follows DIFERENTIAL_CFG_CHECKSUM_EN like the design.
module tb_diferential_cfg_loader;
    localparam int CELLS = 9;
    localparam int CW    = 4;
    localparam int W     = CELLS * CW;

    logic          clk = 1'b0;
    logic          reset, start, din_valid;
    logic [CW-1:0] din;
    logic [W-1:0]  cell_cfg;
    logic          fab_rst, busy, done, err;

    diferential_cfg_loader #(.CELLS(CELLS), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
        .cell_cfg(cell_cfg), .fab_rst(fab_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] cfg;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   rst_seen = 1'b1;
    bit   fab_prev = 1'b0;
    int   fab_cnt = 0;
    logic [W-1:0] last_cfg;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    // cell_cfg may only move on the edge closing a fab_rst cycle, two edges after the final nibble.
    always @(negedge clk) begin
        if (!rst_seen) begin
            if (fab_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("commit_cfg", cell_cfg, e.cfg);
                    chk("commit_latency", cyc - e.cyc, 2);
                end
                chk("fab_rst_width", fab_rst, 0);
            end else begin
                chk("cfg_hold", cell_cfg, last_cfg);
            end
        end
        if (fab_rst) fab_cnt++;
        fab_prev = fab_rst;
        last_cfg = cell_cfg;
    end

    task automatic send(input logic [CW-1:0] n, input bit fin, input logic [W-1:0] v);
        din_valid = 1'b1;
        din       = n;
        if (fin) begin
            exp_t e;
            e.cfg = v;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        din_valid = 1'b0;
        din       = 4'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", err, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cfg"}, cell_cfg, 0);
        chk({tag, "_fab_rst"}, fab_rst, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic partial(input logic [W-1:0] v, input int cnt);
        for (int k = 0; k < cnt; k++) send(v[k*CW +: CW], 1'b0, v);
    endtask

    // Full sequence: start, CELLS nibbles (cell 0 first), checksum when built.
    task automatic load(input logic [W-1:0] v, input bit gap, input bit bad, input bit sic);
        logic [CW-1:0] x;
        logic [CW-1:0] nib;
        logic [W-1:0]  prior;
        int            fab0;
        prior = cell_cfg;
        fab0  = fab_cnt;
        x     = '0;
        pulse_start();
        for (int k = 0; k < CELLS; k++) begin
            if (gap) @(negedge clk);
            nib = v[k*CW +: CW];
            x   = x ^ nib;
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
            send(nib, 1'b0, v);
`else
            send(nib, k == CELLS - 1, v);
`endif
            if (gap) chk("busy_in_load", busy, 1);
        end
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
        if (gap) @(negedge clk);
        send(bad ? (x ^ 4'h1) : x, !bad, v);
`endif
        if (sic) begin
            @(negedge clk);
            chk("commit_fab_rst", fab_rst, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("start_in_commit_busy", busy, 0);
        end
        wait_idle();
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
        if (bad) begin
            chk("bad_err", err, 1);
            chk("bad_done", done, 0);
            chk("bad_cfg_hold", cell_cfg, prior);
            chk("bad_no_fab_rst", fab_cnt - fab0, 0);
        end else begin
            chk("load_done", done, 1);
            chk("load_err", err, 0);
        end
`else
        chk("load_done", done, 1);
        chk("load_err", err, 0);
`endif
    endtask

    initial begin
        logic [W-1:0] r;
        reset = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");

        load(36'h987654321, 1'b0, 1'b0, 1'b0);
        chk("basic_cfg", cell_cfg, 36'h987654321);
`ifdef DIFERENTIAL_CFG_CHECKSUM_EN
        load(36'h987654321 ^ 36'h000000110, 1'b0, 1'b1, 1'b0);
        chk("after_bad_cfg", cell_cfg, 36'h987654321);
`endif
        pulse_start();
        partial(36'h000004321, 4);
        load(36'h123456789, 1'b0, 1'b0, 1'b0);
        chk("restart_cfg", cell_cfg, 36'h123456789);

        pulse_start();
        partial(36'h000054321, 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midload_reset");
        load(36'h987654321, 1'b0, 1'b0, 1'b0);

        din_valid = 1'b1; din = 4'hF;
        repeat (3) @(negedge clk);
        din_valid = 1'b0;
        chk("idle_din_ignored", busy, 0);

        load(36'h987654321, 1'b1, 1'b0, 1'b0);
        load(36'hFEDCBA012, 1'b0, 1'b0, 1'b1);
        chk("sic_cfg", cell_cfg, 36'hFEDCBA012);
        for (int i = 0; i < 3; i++) begin
            r = W'({$urandom, $urandom});
            load(r, i[0], 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        chk("sb_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
